mp_add_seq: RTL and testbench
=============================

MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter: LIMBS, default 4, number of 64-bit limbs per operand (W = 64*LIMBS; legal 2..16).
REQ-002 SHALL have port: clk_i  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port: req_valid_i  input  1  request valid.
REQ-005 SHALL have port: req_ready_o  output  1  block can accept a request.
REQ-006 SHALL have port: op_sub_i  input  1  0 = A+B, 1 = A-B.
REQ-007 SHALL have port: term1_i  input  W  operand A, unsigned or two's complement.
REQ-008 SHALL have port: term2_i  input  W  operand B.
REQ-009 SHALL have port: resp_valid_o  output  1  result valid.
REQ-010 SHALL have port: resp_ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port: result_o  output  W  sum or difference, mod 2^W.
REQ-012 SHALL have port: carry_o  output  1  final limb carry-out (sub: 1 = no borrow, A>=B unsigned).
REQ-013 SHALL have port: ovf_o  output  1  signed two's-complement overflow.
REQ-014 SHALL have port: zero_o  output  1  result_o == 0.
REQ-015 SHALL have port: busy_o  output  1  state != IDLE.

Function
REQ-016 SHALL use exactly one instance of the team's 64-bit carry-lookahead adder, time-shared across limbs.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL assert req_ready_o only in IDLE.
REQ-019 In IDLE, on req_valid_i && req_ready_o: latch term1_i, term2_i, op_sub_i; limb index = 0; carry register = op_sub_i; go to RUN.
REQ-020 In RUN, each cycle: adder inputs = A limb[idx], B limb[idx] (inverted if sub), carry register; write the sum to result limb[idx]; carry register <= adder carry-out; idx increments.
REQ-021 SHALL move RUN -> DONE in the cycle that processes idx == LIMBS-1.
REQ-022 Latency: resp_valid_o SHALL rise exactly LIMBS cycles after the accepting edge.
REQ-023 In DONE, resp_valid_o = 1, and result_o/carry_o/ovf_o/zero_o SHALL hold stable until resp_valid_o && resp_ready_i, then go to IDLE.
REQ-024 SHALL accept no new request in the DONE cycle that completes the response handshake; next accept earliest in the following IDLE cycle.
REQ-025 SHALL ignore req_valid_i, term1_i, term2_i, op_sub_i outside IDLE; latched operands are unaffected.
REQ-026 ovf_o SHALL be 1 iff A[W-1] == Beff[W-1] and result_o[W-1] != A[W-1], where Beff = B for add, ~B for sub.
REQ-027 zero_o and ovf_o SHALL be valid only while resp_valid_o = 1; they are 0 otherwise.
REQ-028 result_o and carry_o SHALL keep their last values in IDLE until the next accept.
REQ-029 Arithmetic SHALL be modulo 2^W with no saturation; carry-out beyond the top limb appears only on carry_o.

Reset
REQ-030 On rising clk_i with rst_ni = 0 (any state, including mid-RUN): state = IDLE, idx = 0, carry register = 0, operand and result registers = 0.
REQ-031 During and after reset: resp_valid_o = 0, req_ready_o = 1, busy_o = 0, result_o = 0, carry_o = 0, ovf_o = 0, zero_o = 0.
REQ-032 An operation interrupted by reset SHALL produce no response.

Verification (LIMBS = 4, W = 256)
REQ-033 Add, A = 2^64-1, B = 1 -> result_o = 2^64 (limb1 = 1, others 0), carry_o = 0, ovf_o = 0, resp_valid_o exactly 4 cycles after accept.
REQ-034 Add, A = 2^256-1, B = 1 -> result_o = 0, carry_o = 1, zero_o = 1, ovf_o = 0.
REQ-035 Sub, A = 0, B = 1 -> result_o = 2^256-1, carry_o = 0; Sub, A = 2^255, B = 1 -> result_o = 2^255-1, ovf_o = 1.
REQ-036 Backpressure: hold resp_ready_i = 0 for 5 cycles in DONE -> resp_valid_o = 1, outputs stable, req_ready_o = 0; toggling req_valid_i and the operands meanwhile has no effect.
REQ-037 Reset mid-operation: rst_ni = 0 for one cycle at RUN idx = 2 -> next cycle all outputs 0, req_ready_o = 1; a subsequent add of 5 + 7 returns 12 after 4 cycles.
REQ-038 Back-to-back: 3 requests with resp_ready_i tied 1 -> accepts spaced exactly LIMBS+2 cycles apart, all results correct.

Source files
------------

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one 64-bit carry-lookahead adder is reused
// across LIMBS limbs, least-significant limb first, one limb per cycle.

module mp_cla64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        c_i,
    output logic [63:0] sum_o,
    output logic        c_o
);
    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [15:0] gg;
    logic [15:0] gp;
    logic [15:0] gc;
    logic [3:0]  sg;
    logic [3:0]  sp;
    logic [4:0]  sc;

    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        // 4-bit group generate/propagate, then 16-bit super-groups
        for (int i = 0; i < 16; i++) begin
            gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (&p[4*i+1 +: 3] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end
        for (int s = 0; s < 4; s++) begin
            sg[s] = gg[4*s+3] | (gp[4*s+3] & gg[4*s+2]) | (gp[4*s+3] & gp[4*s+2] & gg[4*s+1])
                  | (&gp[4*s+1 +: 3] & gg[4*s]);
            sp[s] = &gp[4*s +: 4];
        end
        sc[0] = c_i;
        for (int s = 0; s < 4; s++) begin
            sc[s+1] = sg[s] | (sp[s] & sc[s]);
        end
        for (int s = 0; s < 4; s++) begin
            gc[4*s] = sc[s];
            for (int j = 1; j < 4; j++) begin
                gc[4*s+j] = gg[4*s+j-1] | (gp[4*s+j-1] & gc[4*s+j-1]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            c[4*i] = gc[i];
            for (int k = 1; k < 4; k++) begin
                c[4*i+k] = g[4*i+k-1] | (p[4*i+k-1] & c[4*i+k-1]);
            end
        end
        sum_o = p ^ c;
        c_o   = sc[4];
    end
endmodule

module mp_add_seq #(
    parameter int LIMBS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  op_sub_i,
    input  logic [64*LIMBS-1:0]   term1_i,
    input  logic [64*LIMBS-1:0]   term2_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [64*LIMBS-1:0]   result_o,
    output logic                  carry_o,
    output logic                  ovf_o,
    output logic                  zero_o,
    output logic                  busy_o,
    output logic [1:0]            dbg_state_o
);
    localparam int IDXW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    // Request accepted on req_valid_i && req_ready_o at a rising edge; the
    // response is consumed on resp_valid_o && resp_ready_i at a rising edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    sub_q, sub_d;
    logic [LIMBS-1:0][63:0]  a_q, a_d;
    logic [LIMBS-1:0][63:0]  b_q, b_d;
    logic [LIMBS-1:0][63:0]  res_q, res_d;

    logic [63:0]             cla_a;
    logic [63:0]             cla_b;
    logic [63:0]             cla_sum;
    logic                    cla_co;

    mp_cla64 u_cla (
        .a_i   (cla_a),
        .b_i   (cla_b),
        .c_i   (carry_q),
        .sum_o (cla_sum),
        .c_o   (cla_co)
    );

    // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
    assign cla_a = a_q[idx_q];
    assign cla_b = b_q[idx_q] ^ {64{sub_q}};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    a_d     = term1_i;
                    b_d     = term2_i;
                    sub_d   = op_sub_i;
                    carry_d = op_sub_i;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[idx_q] = cla_sum;
                carry_d      = cla_co;
                if (idx_q == IDXW'(LIMBS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    logic a_msb;
    logic beff_msb;
    logic res_msb;

    assign a_msb    = a_q[LIMBS-1][63];
    assign beff_msb = b_q[LIMBS-1][63] ^ sub_q;
    assign res_msb  = res_q[LIMBS-1][63];

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign result_o     = res_q;
    assign carry_o      = carry_q;
    // Flags are only meaningful alongside a valid response.
    assign ovf_o        = resp_valid_o && (a_msb == beff_msb) && (res_msb != a_msb);
    assign zero_o       = resp_valid_o && (res_q == '0);
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq with LIMBS = 4 (256-bit operands).

module tb_mp_add_seq;
    localparam int LIMBS = 4;
    localparam int W     = 256;

    logic         clk_i        = 1'b0;
    logic         rst_ni       = 1'b0;
    logic         req_valid_i  = 1'b0;
    logic         op_sub_i     = 1'b0;
    logic         resp_ready_i = 1'b0;
    logic [W-1:0] term1_i      = '0;
    logic [W-1:0] term2_i      = '0;
    logic         req_ready_o;
    logic         resp_valid_o;
    logic [W-1:0] result_o;
    logic         carry_o;
    logic         ovf_o;
    logic         zero_o;
    logic         busy_o;
    logic [1:0]   dbg_state_o;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    logic [W-1:0] all_ones = '1;
    logic [W-1:0] max_pos  = {1'b0, {(W-1){1'b1}}};
    logic [W-1:0] min_neg  = {1'b1, {(W-1){1'b0}}};

    mp_add_seq #(.LIMBS(LIMBS)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .op_sub_i     (op_sub_i),
        .term1_i      (term1_i),
        .term2_i      (term2_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .result_o     (result_o),
        .carry_o      (carry_o),
        .ovf_o        (ovf_o),
        .zero_o       (zero_o),
        .busy_o       (busy_o),
        .dbg_state_o  (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Full transaction; lat = -1 if the DUT never became ready or never responded.
    task automatic do_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] res,
                         output logic c, output logic o, output logic z);
        int n;
        lat = -1; res = '0; c = 1'b0; o = 1'b0; z = 1'b0;
        n = 0;
        while (!req_ready_o && n < 20) begin step(); n++; end
        if (!req_ready_o) return;
        op_sub_i = sub; term1_i = a; term2_i = b; req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        n = 0;
        while (!resp_valid_o && n < 20) begin step(); n++; end
        if (!resp_valid_o) return;
        lat = n; res = result_o; c = carry_o; o = ovf_o; z = zero_o;
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        tests++; if (resp_valid_o !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b want 0", resp_valid_o); end
        tests++; if (req_ready_o !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %b want 1", req_ready_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy_o); end
        tests++; if (result_o !== '0) begin fails++; $display("FAIL rst_result got %h want 0", result_o); end
        tests++; if (carry_o !== 1'b0) begin fails++; $display("FAIL rst_carry got %b want 0", carry_o); end
        tests++; if (ovf_o !== 1'b0) begin fails++; $display("FAIL rst_ovf got %b want 0", ovf_o); end
        tests++; if (zero_o !== 1'b0) begin fails++; $display("FAIL rst_zero got %b want 0", zero_o); end
        rst_ni = 1'b1;
        step();
        tests++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            fails++; $display("FAIL post_rst ready=%b busy=%b valid=%b want 1 0 0", req_ready_o, busy_o, resp_valid_o);
        end
    endtask

    task automatic test_add_carry_limb();
        int lat; logic [W-1:0] res; logic c, o, z;
        do_op(1'b0, 256'hFFFF_FFFF_FFFF_FFFF, 256'h1, lat, res, c, o, z);
        tests++; if (lat !== 4) begin fails++; $display("FAIL limb_carry_latency got %0d want 4", lat); end
        tests++; if (res !== 256'h1_0000_0000_0000_0000) begin fails++; $display("FAIL limb_carry_result got %h want 2^64", res); end
        tests++; if (c !== 1'b0 || o !== 1'b0 || z !== 1'b0) begin
            fails++; $display("FAIL limb_carry_flags c=%b o=%b z=%b want 0 0 0", c, o, z);
        end
    endtask

    task automatic test_add_wrap();
        int lat; logic [W-1:0] res; logic c, o, z;
        do_op(1'b0, all_ones, 256'h1, lat, res, c, o, z);
        tests++; if (res !== '0) begin fails++; $display("FAIL wrap_result got %h want 0", res); end
        tests++; if (c !== 1'b1 || z !== 1'b1 || o !== 1'b0) begin
            fails++; $display("FAIL wrap_flags c=%b z=%b o=%b want 1 1 0", c, z, o);
        end
        do_op(1'b0, max_pos, 256'h1, lat, res, c, o, z);
        tests++; if (res !== min_neg) begin fails++; $display("FAIL add_ovf_result got %h want 2^255", res); end
        tests++; if (o !== 1'b1 || c !== 1'b0 || z !== 1'b0) begin
            fails++; $display("FAIL add_ovf_flags o=%b c=%b z=%b want 1 0 0", o, c, z);
        end
    endtask

    task automatic test_sub();
        int lat; logic [W-1:0] res; logic c, o, z;
        do_op(1'b1, '0, 256'h1, lat, res, c, o, z);
        tests++; if (res !== all_ones) begin fails++; $display("FAIL sub_borrow_result got %h want all ones", res); end
        tests++; if (c !== 1'b0 || o !== 1'b0 || z !== 1'b0) begin
            fails++; $display("FAIL sub_borrow_flags c=%b o=%b z=%b want 0 0 0", c, o, z);
        end
        do_op(1'b1, min_neg, 256'h1, lat, res, c, o, z);
        tests++; if (res !== max_pos) begin fails++; $display("FAIL sub_ovf_result got %h want 2^255-1", res); end
        tests++; if (o !== 1'b1 || c !== 1'b1) begin fails++; $display("FAIL sub_ovf_flags o=%b c=%b want 1 1", o, c); end
        do_op(1'b1, 256'h5, 256'h5, lat, res, c, o, z);
        tests++; if (res !== '0 || z !== 1'b1 || c !== 1'b1 || o !== 1'b0) begin
            fails++; $display("FAIL sub_equal res=%h z=%b c=%b o=%b want 0 1 1 0", res, z, c, o);
        end
        tests++; if (lat !== 4) begin fails++; $display("FAIL sub_latency got %0d want 4", lat); end
    endtask

    task automatic test_backpressure();
        int n;
        op_sub_i = 1'b0; term1_i = 256'h3; term2_i = 256'h4; req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        n = 0;
        while (!resp_valid_o && n < 20) begin step(); n++; end
        tests++; if (n !== 4) begin fails++; $display("FAIL bp_latency got %0d want 4", n); end
        for (int i = 0; i < 5; i++) begin
            req_valid_i = 1'($urandom_range(0, 1));
            op_sub_i    = 1'($urandom_range(0, 1));
            term1_i     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            term2_i     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            step();
            tests++; if (resp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                fails++; $display("FAIL bp_hold_ctrl cyc=%0d valid=%b ready=%b busy=%b want 1 0 1", i, resp_valid_o, req_ready_o, busy_o);
            end
            tests++; if (result_o !== 256'h7 || carry_o !== 1'b0 || zero_o !== 1'b0 || ovf_o !== 1'b0) begin
                fails++; $display("FAIL bp_hold_data cyc=%0d res=%h c=%b z=%b o=%b want 7 0 0 0", i, result_o, carry_o, zero_o, ovf_o);
            end
        end
        // A request presented in the handshake cycle must not be taken.
        req_valid_i = 1'b1; op_sub_i = 1'b0; term1_i = 256'd100; term2_i = 256'd200;
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        tests++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            fails++; $display("FAIL bp_no_accept_on_handshake busy=%b ready=%b valid=%b want 0 1 0", busy_o, req_ready_o, resp_valid_o);
        end
        tests++; if (result_o !== 256'h7 || carry_o !== 1'b0 || zero_o !== 1'b0 || ovf_o !== 1'b0) begin
            fails++; $display("FAIL idle_hold res=%h c=%b z=%b o=%b want 7 0 0 0", result_o, carry_o, zero_o, ovf_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat; int seen; logic [W-1:0] res; logic c, o, z;
        op_sub_i = 1'b0; term1_i = {4{64'h1111_2222_3333_4444}}; term2_i = {4{64'h0101_0101_0101_0101}};
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();
        step();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        tests++; if (result_o !== '0 || carry_o !== 1'b0 || ovf_o !== 1'b0 || zero_o !== 1'b0) begin
            fails++; $display("FAIL midrst_data res=%h c=%b o=%b z=%b want 0 0 0 0", result_o, carry_o, ovf_o, zero_o);
        end
        tests++; if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            fails++; $display("FAIL midrst_ctrl ready=%b busy=%b valid=%b want 1 0 0", req_ready_o, busy_o, resp_valid_o);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (resp_valid_o === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_resp got %0d responses want 0", seen); end
        do_op(1'b0, 256'd5, 256'd7, lat, res, c, o, z);
        tests++; if (res !== 256'd12 || lat !== 4) begin
            fails++; $display("FAIL midrst_after res=%h lat=%0d want 12 4", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_v[3];
        logic [W-1:0] b_v[3];
        logic         s_v[3];
        logic [W-1:0] r_v[3];
        int           acc_t[3];
        logic [W-1:0] exp_r;
        int           k;
        a_v[0] = 256'h1234;   b_v[0] = 256'h1111; s_v[0] = 1'b0; r_v[0] = 256'h2345;
        a_v[1] = 256'd100;    b_v[1] = 256'd58;   s_v[1] = 1'b1; r_v[1] = 256'd42;
        a_v[2] = {64'h1, {3{64'hFFFF_FFFF_FFFF_FFFF}}}; b_v[2] = 256'h1; s_v[2] = 1'b0;
        r_v[2] = {64'h2, 192'h0};
        for (int i = 0; i < 3; i++) acc_t[i] = -1;
        resp_ready_i = 1'b1;
        k = 0;
        op_sub_i = s_v[0]; term1_i = a_v[0]; term2_i = b_v[0]; req_valid_i = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (resp_valid_o === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL b2b_extra_resp got %h want none", result_o);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (result_o !== exp_r) begin fails++; $display("FAIL b2b_result got %h want %h", result_o, exp_r); end
                end
            end
            if (k < 3 && req_ready_o === 1'b1) begin
                acc_t[k] = cyc;
                exp_q.push_back(r_v[k]);
                k++;
            end
            step();
            if (k < 3) begin
                op_sub_i = s_v[k]; term1_i = a_v[k]; term2_i = b_v[k];
            end else begin
                req_valid_i = 1'b0;
            end
            if (k == 3 && exp_q.size() == 0) break;
        end
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        tests++; if (k !== 3 || exp_q.size() !== 0) begin
            fails++; $display("FAIL b2b_count accepted=%0d pending=%0d want 3 0", k, exp_q.size());
        end
        tests++; if (acc_t[1] - acc_t[0] !== LIMBS + 2) begin
            fails++; $display("FAIL b2b_spacing01 got %0d want %0d", acc_t[1] - acc_t[0], LIMBS + 2);
        end
        tests++; if (acc_t[2] - acc_t[1] !== LIMBS + 2) begin
            fails++; $display("FAIL b2b_spacing12 got %0d want %0d", acc_t[2] - acc_t[1], LIMBS + 2);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_add_carry_limb();
        test_add_wrap();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
